// File: rtl/rsp_merger_pkg.sv
// Shared widths, fail reason codes and the response entry bundle
// for the alloc/free response merger.
package rsp_merger_pkg;

  localparam int REQ_ID_WIDTH       = 8;
  localparam int ALL_PAGE_IDX_WIDTH = 12;
  localparam int FAIL_REASON_WIDTH  = 3;
  localparam int HOLD_DEPTH         = 4;

  localparam logic [FAIL_REASON_WIDTH-1:0] FAIL_REASON_NONE = 3'd0;
  localparam logic [FAIL_REASON_WIDTH-1:0] FAIL_REASON_ZERO = 3'd1;
  localparam logic [FAIL_REASON_WIDTH-1:0] FAIL_REASON_OVER_4KB = 3'd2;
  localparam logic [FAIL_REASON_WIDTH-1:0] ALLOC_FAIL_REASON_NO_SPACE = 3'd3;
  localparam logic [FAIL_REASON_WIDTH-1:0] FREE_FAIL_REASON_NOT_ALLOCATED = 3'd4;

  typedef struct packed {
    logic [REQ_ID_WIDTH-1:0]       id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
    logic                          fail;
    logic [FAIL_REASON_WIDTH-1:0]  reason;
  } rsp_t;

endpackage

// File: rtl/rsp_merge_channel.sv
// One response channel: 2-push/1-pop hold queue with bypass,
// registered FIFO write port, almost_full and sticky overflow.
module rsp_merge_channel
  import rsp_merger_pkg::*;
#(
  parameter int DEPTH         = HOLD_DEPTH,
  parameter bit WITH_PAGE_IDX = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic disp_valid,
  input  rsp_t disp,
  input  logic eng_valid,
  input  rsp_t eng,
  input  logic fifo_full,
  output logic write_en,
  output rsp_t rsp,
  output logic almost_full,
  output logic overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rsp_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          acc_d;
  logic          acc_e;
  logic [CW-1:0] avail;
  logic [1:0]    n_acc;
  rsp_t          first;
  rsp_t          head;

  // an empty queue pops the first incoming entry directly (bypass)
  always_comb begin
    pop   = !fifo_full && (count != '0 || disp_valid || eng_valid);
    avail = CW'(DEPTH) - count + CW'(pop);
    acc_d = disp_valid && avail != '0;
    acc_e = eng_valid && (acc_d ? avail >= CW'(2) : avail != '0);
    n_acc = {1'b0, acc_d} + {1'b0, acc_e};
    first = acc_d ? disp : eng;
    head  = (count != '0) ? mem[rd_ptr] : first;
  end

  always_ff @(posedge clk) begin
    if (acc_d || acc_e)
      mem[wr_ptr] <= first;
    if (acc_d && acc_e)
      mem[wr_ptr + 1'b1] <= eng;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      write_en <= 1'b0;
      rsp      <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(n_acc);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count + CW'(n_acc) - CW'(pop);
      overflow <= overflow
                | (disp_valid && !acc_d)
                | (eng_valid && !acc_e);
      write_en <= pop;
      if (pop) begin
        rsp <= head;
        if (!WITH_PAGE_IDX)
          rsp.page_idx <= '0;
      end
    end
  end

  assign almost_full = count >= CW'(DEPTH - 1);

endmodule

// File: rtl/rsp_merger.sv
// Merges dispatcher fail pulses with FDT / or_tree results into
// the alloc and free response FIFO write ports.
module rsp_merger
  import rsp_merger_pkg::*;
#(
  parameter int HOLD_DEPTH = rsp_merger_pkg::HOLD_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_alloc_valid,
  input  logic [REQ_ID_WIDTH-1:0]       disp_alloc_id,
  input  logic [FAIL_REASON_WIDTH-1:0]  disp_alloc_fail_reason,
  input  logic                          fdt_alloc_valid,
  input  logic [REQ_ID_WIDTH-1:0]       fdt_alloc_id,
  input  logic [ALL_PAGE_IDX_WIDTH-1:0] fdt_alloc_page_idx,
  input  logic                          fdt_alloc_fail,
  input  logic [FAIL_REASON_WIDTH-1:0]  fdt_alloc_reason,
  input  logic                          disp_free_valid,
  input  logic [REQ_ID_WIDTH-1:0]       disp_free_id,
  input  logic [FAIL_REASON_WIDTH-1:0]  disp_free_reason,
  input  logic                          tree_free_valid,
  input  logic [REQ_ID_WIDTH-1:0]       tree_free_id,
  input  logic                          tree_free_fail,
  input  logic [FAIL_REASON_WIDTH-1:0]  tree_free_reason,
  input  logic                          alloc_rsp_fifo_full,
  output logic                          alloc_rsp_write_en,
  output logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id,
  output logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx,
  output logic                          alloc_rsp_fail,
  output logic [FAIL_REASON_WIDTH-1:0]  alloc_rsp_reason,
  input  logic                          free_rsp_fifo_full,
  output logic                          free_rsp_write_en,
  output logic [REQ_ID_WIDTH-1:0]       free_rsp_id,
  output logic                          free_rsp_fail,
  output logic [FAIL_REASON_WIDTH-1:0]  free_rsp_reason,
  output logic                          alloc_hold_almost_full,
  output logic                          free_hold_almost_full,
  output logic                          alloc_hold_overflow,
  output logic                          free_hold_overflow
);

  rsp_t a_disp, a_eng, a_q;
  rsp_t f_disp, f_eng, f_q;
  logic [ALL_PAGE_IDX_WIDTH-1:0] free_pi_unused;

  assign a_disp = '{id: disp_alloc_id, page_idx: '0,
                    fail: 1'b1, reason: disp_alloc_fail_reason};
  assign a_eng  = '{id: fdt_alloc_id, page_idx: fdt_alloc_page_idx,
                    fail: fdt_alloc_fail, reason: fdt_alloc_reason};
  assign f_disp = '{id: disp_free_id, page_idx: '0,
                    fail: 1'b1, reason: disp_free_reason};
  assign f_eng  = '{id: tree_free_id, page_idx: '0,
                    fail: tree_free_fail, reason: tree_free_reason};

  rsp_merge_channel #(
    .DEPTH(HOLD_DEPTH), .WITH_PAGE_IDX(1'b1)
  ) u_alloc (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_alloc_valid), .disp(a_disp),
    .eng_valid(fdt_alloc_valid), .eng(a_eng),
    .fifo_full(alloc_rsp_fifo_full),
    .write_en(alloc_rsp_write_en), .rsp(a_q),
    .almost_full(alloc_hold_almost_full),
    .overflow(alloc_hold_overflow)
  );

  rsp_merge_channel #(
    .DEPTH(HOLD_DEPTH), .WITH_PAGE_IDX(1'b0)
  ) u_free (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_free_valid), .disp(f_disp),
    .eng_valid(tree_free_valid), .eng(f_eng),
    .fifo_full(free_rsp_fifo_full),
    .write_en(free_rsp_write_en), .rsp(f_q),
    .almost_full(free_hold_almost_full),
    .overflow(free_hold_overflow)
  );

  assign alloc_rsp_id       = a_q.id;
  assign alloc_rsp_page_idx = a_q.page_idx;
  assign alloc_rsp_fail     = a_q.fail;
  assign alloc_rsp_reason   = a_q.reason;
  assign free_rsp_id        = f_q.id;
  assign free_rsp_fail      = f_q.fail;
  assign free_rsp_reason    = f_q.reason;
  assign free_pi_unused     = f_q.page_idx;

endmodule

// File: tb/tb_rsp_merger.sv
// Directed and random stimulus for rsp_merger against a
// queue-based reference model of both channels.
module tb_rsp_merger;
  import rsp_merger_pkg::*;

  localparam int D = HOLD_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic disp_alloc_valid = 0;
  logic [REQ_ID_WIDTH-1:0] disp_alloc_id = 0;
  logic [FAIL_REASON_WIDTH-1:0] disp_alloc_fail_reason = 0;
  logic fdt_alloc_valid = 0;
  logic [REQ_ID_WIDTH-1:0] fdt_alloc_id = 0;
  logic [ALL_PAGE_IDX_WIDTH-1:0] fdt_alloc_page_idx = 0;
  logic fdt_alloc_fail = 0;
  logic [FAIL_REASON_WIDTH-1:0] fdt_alloc_reason = 0;
  logic disp_free_valid = 0;
  logic [REQ_ID_WIDTH-1:0] disp_free_id = 0;
  logic [FAIL_REASON_WIDTH-1:0] disp_free_reason = 0;
  logic tree_free_valid = 0;
  logic [REQ_ID_WIDTH-1:0] tree_free_id = 0;
  logic tree_free_fail = 0;
  logic [FAIL_REASON_WIDTH-1:0] tree_free_reason = 0;
  logic alloc_rsp_fifo_full = 0;
  logic free_rsp_fifo_full = 0;
  logic alloc_rsp_write_en;
  logic [REQ_ID_WIDTH-1:0] alloc_rsp_id;
  logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx;
  logic alloc_rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0] alloc_rsp_reason;
  logic free_rsp_write_en;
  logic [REQ_ID_WIDTH-1:0] free_rsp_id;
  logic free_rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0] free_rsp_reason;
  logic alloc_hold_almost_full, free_hold_almost_full;
  logic alloc_hold_overflow, free_hold_overflow;

  rsp_merger dut (
    .clk(clk), .rst_n(rst_n),
    .disp_alloc_valid(disp_alloc_valid),
    .disp_alloc_id(disp_alloc_id),
    .disp_alloc_fail_reason(disp_alloc_fail_reason),
    .fdt_alloc_valid(fdt_alloc_valid),
    .fdt_alloc_id(fdt_alloc_id),
    .fdt_alloc_page_idx(fdt_alloc_page_idx),
    .fdt_alloc_fail(fdt_alloc_fail),
    .fdt_alloc_reason(fdt_alloc_reason),
    .disp_free_valid(disp_free_valid),
    .disp_free_id(disp_free_id),
    .disp_free_reason(disp_free_reason),
    .tree_free_valid(tree_free_valid),
    .tree_free_id(tree_free_id),
    .tree_free_fail(tree_free_fail),
    .tree_free_reason(tree_free_reason),
    .alloc_rsp_fifo_full(alloc_rsp_fifo_full),
    .alloc_rsp_write_en(alloc_rsp_write_en),
    .alloc_rsp_id(alloc_rsp_id),
    .alloc_rsp_page_idx(alloc_rsp_page_idx),
    .alloc_rsp_fail(alloc_rsp_fail),
    .alloc_rsp_reason(alloc_rsp_reason),
    .free_rsp_fifo_full(free_rsp_fifo_full),
    .free_rsp_write_en(free_rsp_write_en),
    .free_rsp_id(free_rsp_id),
    .free_rsp_fail(free_rsp_fail),
    .free_rsp_reason(free_rsp_reason),
    .alloc_hold_almost_full(alloc_hold_almost_full),
    .free_hold_almost_full(free_hold_almost_full),
    .alloc_hold_overflow(alloc_hold_overflow),
    .free_hold_overflow(free_hold_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pi;
    int fail;
    int rs;
  } e_t;

  e_t q[2][$];
  e_t eout[2];
  bit ewe[2], eaf[2], eov[2];
  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      q[c].delete();
      eout[c] = '{0, 0, 0, 0};
      ewe[c] = 0;
      eaf[c] = 0;
      eov[c] = 0;
    end
  endtask

  // one cycle of a channel: the pop frees its slot first, then
  // arrivals are taken in dispatcher-then-engine order while room lasts
  task automatic mstep(int c, bit dv, e_t de, bit ev, e_t ee, bit full);
    bit pop;
    int room;
    pop = !full && (q[c].size() > 0 || dv || ev);
    room = D - q[c].size() + (pop ? 1 : 0);
    if (dv) begin
      if (room > 0) begin q[c].push_back(de); room--; end
      else eov[c] = 1;
    end
    if (ev) begin
      if (room > 0) begin q[c].push_back(ee); room--; end
      else eov[c] = 1;
    end
    ewe[c] = pop;
    if (pop) eout[c] = q[c].pop_front();
    eaf[c] = q[c].size() >= D - 1;
  endtask

  task automatic compare();
    check("a_we", 32'(alloc_rsp_write_en), 32'(ewe[0]));
    check("a_id", 32'(alloc_rsp_id), eout[0].id);
    check("a_pi", 32'(alloc_rsp_page_idx), eout[0].pi);
    check("a_fail", 32'(alloc_rsp_fail), eout[0].fail);
    check("a_rs", 32'(alloc_rsp_reason), eout[0].rs);
    check("a_af", 32'(alloc_hold_almost_full), 32'(eaf[0]));
    check("a_ov", 32'(alloc_hold_overflow), 32'(eov[0]));
    check("f_we", 32'(free_rsp_write_en), 32'(ewe[1]));
    check("f_id", 32'(free_rsp_id), eout[1].id);
    check("f_fail", 32'(free_rsp_fail), eout[1].fail);
    check("f_rs", 32'(free_rsp_reason), eout[1].rs);
    check("f_af", 32'(free_hold_almost_full), 32'(eaf[1]));
    check("f_ov", 32'(free_hold_overflow), 32'(eov[1]));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_a_we"}, 32'(alloc_rsp_write_en), 0);
    check({tag, "_a_id"}, 32'(alloc_rsp_id), 0);
    check({tag, "_a_pi"}, 32'(alloc_rsp_page_idx), 0);
    check({tag, "_a_fail"}, 32'(alloc_rsp_fail), 0);
    check({tag, "_a_rs"}, 32'(alloc_rsp_reason), 0);
    check({tag, "_f_we"}, 32'(free_rsp_write_en), 0);
    check({tag, "_f_id"}, 32'(free_rsp_id), 0);
    check({tag, "_f_fail"}, 32'(free_rsp_fail), 0);
    check({tag, "_f_rs"}, 32'(free_rsp_reason), 0);
    check({tag, "_a_af"}, 32'(alloc_hold_almost_full), 0);
    check({tag, "_f_af"}, 32'(free_hold_almost_full), 0);
    check({tag, "_a_ov"}, 32'(alloc_hold_overflow), 0);
    check({tag, "_f_ov"}, 32'(free_hold_overflow), 0);
  endtask

  task automatic step();
    e_t ad, ae, fd, fe;
    ad = '{int'(disp_alloc_id), 0, 1, int'(disp_alloc_fail_reason)};
    ae = '{int'(fdt_alloc_id), int'(fdt_alloc_page_idx),
           int'(fdt_alloc_fail), int'(fdt_alloc_reason)};
    fd = '{int'(disp_free_id), 0, 1, int'(disp_free_reason)};
    fe = '{int'(tree_free_id), 0, int'(tree_free_fail),
           int'(tree_free_reason)};
    mstep(0, disp_alloc_valid, ad, fdt_alloc_valid, ae,
          alloc_rsp_fifo_full);
    mstep(1, disp_free_valid, fd, tree_free_valid, fe,
          free_rsp_fifo_full);
    @(posedge clk);
    @(negedge clk);
    compare();
    disp_alloc_valid = 0;
    fdt_alloc_valid = 0;
    disp_free_valid = 0;
    tree_free_valid = 0;
  endtask

  task automatic fdt(int id, int pi, bit f, int rs);
    fdt_alloc_valid = 1;
    fdt_alloc_id = REQ_ID_WIDTH'(id);
    fdt_alloc_page_idx = ALL_PAGE_IDX_WIDTH'(pi);
    fdt_alloc_fail = f;
    fdt_alloc_reason = FAIL_REASON_WIDTH'(rs);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1;

    // single FDT result, bypass latency of one cycle
    fdt(5, 'h123, 0, 0);
    step();
    step();

    // tie: dispatcher first, then engine
    disp_alloc_valid = 1;
    disp_alloc_id = 3;
    disp_alloc_fail_reason = FAIL_REASON_ZERO;
    fdt(4, 'h044, 0, 0);
    step();
    step();
    step();

    // FIFO full for 6 cycles with 3 arrivals
    alloc_rsp_fifo_full = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) fdt(10 + i, 'h200 + i, i == 1, i);
      step();
    end
    alloc_rsp_fifo_full = 0;
    for (int i = 0; i < 4; i++) step();

    // free channel tie while alloc traffic runs
    tree_free_valid = 1;
    tree_free_id = 7;
    tree_free_fail = 0;
    tree_free_reason = 0;
    disp_free_valid = 1;
    disp_free_id = 9;
    disp_free_reason = FAIL_REASON_OVER_4KB;
    fdt(20, 'h0ab, 0, 0);
    step();
    fdt(21, 'h0ac, 1, ALLOC_FAIL_REASON_NO_SPACE);
    step();
    for (int i = 0; i < 3; i++) step();

    // fill queue while full, then both sources collide
    alloc_rsp_fifo_full = 1;
    for (int i = 0; i < 4; i++) begin
      fdt(30 + i, 'h300 + i, 0, 0);
      step();
    end
    disp_alloc_valid = 1;
    disp_alloc_id = 40;
    disp_alloc_fail_reason = FAIL_REASON_ZERO;
    fdt(41, 'h341, 0, 0);
    step();
    step();
    alloc_rsp_fifo_full = 0;
    for (int i = 0; i < 6; i++) step();

    // randomized traffic on both channels
    for (int i = 0; i < 400; i++) begin
      disp_alloc_valid = 1'($urandom_range(0, 1));
      disp_alloc_id = REQ_ID_WIDTH'($urandom);
      disp_alloc_fail_reason = FAIL_REASON_WIDTH'($urandom);
      if ($urandom_range(0, 1) == 1)
        fdt(int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      disp_free_valid = 1'($urandom_range(0, 1));
      disp_free_id = REQ_ID_WIDTH'($urandom);
      disp_free_reason = FAIL_REASON_WIDTH'($urandom);
      tree_free_valid = 1'($urandom_range(0, 1));
      tree_free_id = REQ_ID_WIDTH'($urandom);
      tree_free_fail = 1'($urandom_range(0, 1));
      tree_free_reason = FAIL_REASON_WIDTH'($urandom);
      alloc_rsp_fifo_full = ($urandom_range(0, 3) == 0);
      free_rsp_fifo_full = ($urandom_range(0, 2) == 0);
      step();
    end
    free_rsp_fifo_full = 0;
    for (int i = 0; i < 6; i++) step();

    // reset with 3 entries queued
    alloc_rsp_fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      fdt(50 + i, 'h150 + i, 1, 2);
      step();
    end
    #2 rst_n = 0;
    #1 check_zero("midrst");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    alloc_rsp_fifo_full = 0;
    for (int i = 0; i < 5; i++) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
